spi_slave_if: RTL and testbench

Serial front end for the single-port RAM. Receives SPI frames on MOSI while SS_n is low, assembles each into a 10-bit command word and presents it to the RAM on rx_data/rx_valid. For read-data frames it waits for the RAM's tx_valid, loads tx_data and shifts it out on MISO, MSB first. It sits between the external SPI master and the RAM, driving the RAM's din/rx_valid and consuming its dout/tx_valid.

---
 rtl/spi_slave_if_pkg.sv | 20 ++
 rtl/spi_slave_if_piso_shift.sv | 36 +++
 rtl/spi_slave_if.sv | 101 ++++++++++
 tb/tb_spi_slave_if.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_slave_pkg;

  localparam int DEF_CMD_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

endpackage

// File: rtl/spi_slave_if_piso_shift.sv
// Parallel-load, serial-out shifter driving MISO, MSB first, with a down-counter
// of bits still to send; done flags the cycle the last bit is on the line.
module spi_piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         miso,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  shift;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift <= '0;
      cnt   <= '0;
    end else if (load) begin
      shift <= din;
      cnt   <= CW'(W);
    end else if (cnt != '0) begin
      shift <= {shift[W-2:0], 1'b0};
      cnt   <= cnt - CW'(1);
    end
  end

  assign miso = (cnt != '0) && shift[W-1];
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles 10-bit command words for the RAM and returns
// read data on MISO.
//   state     | meaning
//   IDLE      | waiting for SS_n low
//   CHK_CMD   | sampling the mode bit
//   WRITE     | shifting a write-address / write-data word
//   READ_ADD  | shifting a read-address word, sets rd_addr_flag when complete
//   READ_DATA | shifting a read-data word, then returning 8 bits on MISO
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [CMD_WIDTH-1:0]  rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int RXC_W = $clog2(CMD_WIDTH + 1);

  state_t               state, next_state;
  logic [RXC_W-1:0]     rx_cnt;
  logic [CMD_WIDTH-2:0] rx_shift;
  logic                 rd_addr_flag;
  logic                 tx_loaded;

  logic frame_start, shift_en, rx_last, piso_load, piso_done, flag_set, flag_clr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (!rd_addr_flag) next_state = READ_ADD;
        else                   next_state = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read data is loaded only once rx_valid has dropped, so the RAM has had a
  // cycle to act on the read command even if tx_valid is still high from before.
  always_comb begin
    frame_start = (state == CHK_CMD) && !SS_n;
    shift_en    = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                  && !SS_n && (rx_cnt != '0);
    rx_last     = shift_en && (rx_cnt == RXC_W'(1));
    piso_load   = (state == READ_DATA) && !SS_n && (rx_cnt == '0) && !rx_valid
                  && tx_valid && !tx_loaded;
    flag_set    = (state == READ_ADD) && rx_last;
    flag_clr    = (state == READ_DATA) && piso_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_loaded    <= 1'b0;
    end else begin
      rx_valid <= rx_last;
      if (SS_n || (state == IDLE)) rx_cnt <= '0;
      else if (frame_start)        rx_cnt <= RXC_W'(CMD_WIDTH);
      else if (shift_en)           rx_cnt <= rx_cnt - RXC_W'(1);
      if (shift_en) rx_shift <= {rx_shift[CMD_WIDTH-3:0], MOSI};
      if (rx_last)  rx_data  <= {rx_shift, MOSI};
      if (flag_set)      rd_addr_flag <= 1'b1;
      else if (flag_clr) rd_addr_flag <= 1'b0;
      if (next_state != READ_DATA) tx_loaded <= 1'b0;
      else if (piso_load)          tx_loaded <= 1'b1;
    end
  end

  spi_piso_shift #(.W(DATA_WIDTH)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .clr  (SS_n),
    .load (piso_load),
    .din  (tx_data),
    .miso (MISO),
    .done (piso_done)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed-vector bench for spi_slave_if: stimulus queues expected rx words and
// per-cycle MISO values; a negedge monitor pops and compares them.
module tb_spi_slave_if;
  import spi_slave_pkg::*;

  typedef struct {
    logic [9:0] data;
    int         cyc;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       rst, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  rx_exp_t rx_q[$];
  logic    miso_q[$];

  spi_slave_if #(.CMD_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    rx_exp_t e;
    logic    em;
    if (miso_q.size() != 0) begin
      em = miso_q.pop_front();
      check("miso", 32'(MISO), 32'(em));
    end
    if (rx_valid === 1'b1) begin
      if (rx_q.size() == 0) begin
        check("unexpected_rx_valid", 32'(rx_valid), 32'd0);
      end else begin
        e = rx_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("rx_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One cycle: push the MISO expected in this cycle, set inputs for the next edge.
  task automatic step(input logic ss, input logic mosi, input logic tv, input logic r,
                      input logic em);
    @(posedge clk);
    #1;
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = tv;
    rst      = r;
    miso_q.push_back(em);
  endtask

  // tv_mode: 0 none, 1 RAM answers one cycle after rx_valid, 2 held high all frame.
  task automatic do_frame(input logic mode, input logic [9:0] bits, input int nbits,
                          input int tv_mode, input logic [7:0] td, input bit exp_out,
                          input int rst_after);
    logic stale, tv, r, em;
    stale   = (tv_mode == 2);
    tv      = (tv_mode != 0);
    tx_data = td;
    step(1'b0, 1'b0, stale, 1'b0, 1'b0);
    if (nbits == 10) rx_q.push_back('{bits, cyc + 12});
    step(1'b0, mode, stale, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) step(1'b0, bits[9-i], stale, 1'b0, 1'b0);
    if (nbits < 10) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      step(1'b0, 1'b0, stale, 1'b0, 1'b0);
      step(1'b0, 1'b0, tv, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        r  = (rst_after >= 0) && (i >= rst_after - 1);
        em = exp_out && ((rst_after < 0) || (i < rst_after)) && td[7-i];
        step(r, 1'b0, tv && !r, r, em);
      end
      r = (rst_after >= 0);
      step(r, 1'b0, tv && !r, r, 1'b0);
      if (r) check("rx_data_after_rst", 32'(rx_data), 32'd0);
      step(r, 1'b0, tv && !r, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    do_frame(1'b0, {WR_ADDR, 8'h05}, 10, 0, 8'h00, 1'b0, -1);  // 10'h005
    do_frame(1'b0, {WR_DATA, 8'hAA}, 10, 0, 8'h00, 1'b0, -1);  // 10'h1AA
    do_frame(1'b1, {RD_ADDR, 8'h05}, 10, 0, 8'h00, 1'b0, -1);  // 10'h205, flag set
    do_frame(1'b0, {WR_DATA, 8'h55}, 10, 0, 8'h00, 1'b0, -1);  // flag must survive
    do_frame(1'b1, {RD_DATA, 8'h00}, 10, 1, 8'hAA, 1'b1, -1);  // MISO 10101010
    do_frame(1'b1, {RD_ADDR, 8'h07}, 10, 0, 8'h00, 1'b0, -1);
    do_frame(1'b1, {RD_DATA, 8'h00}, 10, 2, 8'h3C, 1'b1, -1);  // stale tx_valid
    do_frame(1'b0, {WR_ADDR, 8'hF3}, 5, 0, 8'h00, 1'b0, -1);   // aborted
    do_frame(1'b0, {WR_ADDR, 8'hF3}, 10, 0, 8'h00, 1'b0, -1);
    do_frame(1'b1, {RD_ADDR, 8'hAB}, 10, 0, 8'h00, 1'b0, -1);
    do_frame(1'b1, {RD_DATA, 8'h00}, 10, 1, 8'hC5, 1'b1, 3);   // rst after 3 bits
    do_frame(1'b1, {RD_ADDR, 8'h11}, 10, 2, 8'h5A, 1'b0, -1);  // flag was cleared
    do_frame(1'b1, {RD_DATA, 8'h00}, 10, 1, 8'h5A, 1'b1, -1);

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rx_pending", 32'(rx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
